// File: rtl/fetch_unit_if.sv
// Fetch unit bus: ROM address/data, control decode inputs, IR field and status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the fetch unit runs every cycle in RUN, and the Control/ROM side reacts combinationally.
interface fetch_unit_if #(
  parameter int PC_WIDTH = 10
);
  logic                Start;
  logic [8:0]          InstrIn;
  logic                Branch;
  logic                BranchCond;
  logic                Zero;
  logic [PC_WIDTH-1:0] BranchTarget;
  logic                Halt;
  logic [PC_WIDTH-1:0] IMemAddr;
  logic [2:0]          Opcode;
  logic [2:0]          Funct;
  logic [2:0]          Operand;
  logic                IRValid;
  logic                Done;

  // Fetch unit side: owns the PC and the instruction register.
  modport master (
    input  Start, InstrIn, Branch, BranchCond, Zero, BranchTarget, Halt,
    output IMemAddr, Opcode, Funct, Operand, IRValid, Done
  );

  // Environment side: instruction ROM, Control and datapath.
  modport slave (
    output Start, InstrIn, Branch, BranchCond, Zero, BranchTarget, Halt,
    input  IMemAddr, Opcode, Funct, Operand, IRValid, Done
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC + IR with IDLE/RUN/HALTED control, branch redirect and halt.
// Latency: one cycle from PC to IR; a taken branch inserts one bubble.
// Backpressure: none; fetches every RUN cycle, Start is ignored while running.
module fetch_unit #(
  parameter int PC_WIDTH   = 10,
  parameter int START_ADDR = 0
) (
  input logic          CLK,
  input logic          Reset,
  fetch_unit_if.master bus
);

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [8:0]          ir_q, ir_d;
  logic                vld_q, vld_d;
  logic                taken;

  // Branch/Halt decode refers to the IR, so it only counts when the IR is live.
  assign taken = vld_q & bus.Branch & (~bus.BranchCond | bus.Zero);

  // Next-state: start/restart, sequential fetch, redirect, halt (halt wins over branch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE, HALTED: begin
        vld_d = 1'b0;
        if (bus.Start) begin
          pc_d    = START_PC;
          state_d = RUN;
        end
      end
      RUN: begin
        if (vld_q & bus.Halt) begin
          state_d = HALTED;
          vld_d   = 1'b0;
        end else if (taken) begin
          // The word fetched at the old PC is dropped; IR keeps its last value.
          pc_d  = bus.BranchTarget;
          vld_d = 1'b0;
        end else begin
          ir_d  = bus.InstrIn;
          vld_d = 1'b1;
          pc_d  = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State register; Reset overrides everything in the same cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      ir_q    <= 9'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.IMemAddr = pc_q;
  assign bus.Opcode   = ir_q[8:6];
  assign bus.Operand  = ir_q[5:3];
  assign bus.Funct    = ir_q[2:0];
  assign bus.IRValid  = vld_q;
  assign bus.Done     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random control traffic against a rule-level model.
// Latency: one step per clock; outputs compared at the falling edge.
// Backpressure: none; the bench drives a new input set every cycle.
module tb_fetch_unit;

  localparam int PW = 10;
  localparam int ROM_WORDS = 1 << PW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] rom [0:ROM_WORDS-1];

  int chk_cnt  = 0;
  int fail_cnt = 0;

  fetch_unit_if #(.PC_WIDTH(PW)) bus ();

  fetch_unit #(.PC_WIDTH(PW), .START_ADDR(0)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.InstrIn = rom[bus.IMemAddr];

  // Reference: what the program counter, instruction register and status should be.
  // mode: 0 = not started, 1 = running, 2 = halted
  int              m_mode;
  logic [PW-1:0]   m_pc;
  logic [8:0]      m_ir;
  bit              m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the rules, then compare.
  task automatic step(input bit r, input bit s, input bit b, input bit bc, input bit z,
                      input logic [PW-1:0] tgt, input bit h);
    rst              = r;
    bus.Start        = s;
    bus.Branch       = b;
    bus.BranchCond   = bc;
    bus.Zero         = z;
    bus.BranchTarget = tgt;
    bus.Halt         = h;

    if (r) begin
      m_mode = 0; m_pc = '0; m_ir = '0; m_vld = 0;
    end else if (m_mode != 1) begin
      m_vld = 0;
      if (s) begin
        m_pc = '0; m_mode = 1;
      end
    end else if (m_vld && h) begin
      m_mode = 2; m_vld = 0;
    end else if (m_vld && b && (!bc || z)) begin
      m_pc = tgt; m_vld = 0;
    end else begin
      m_ir  = rom[m_pc];
      m_vld = 1;
      m_pc  = m_pc + 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    chk("imem_addr", 32'(bus.IMemAddr), 32'(m_pc));
    chk("ir_valid",  32'(bus.IRValid),  32'(m_vld));
    chk("done",      32'(bus.Done),     32'(m_mode == 2));
    if (m_vld) begin
      chk("opcode",  32'(bus.Opcode),  32'(m_ir[8:6]));
      chk("operand", 32'(bus.Operand), 32'(m_ir[5:3]));
      chk("funct",   32'(bus.Funct),   32'(m_ir[2:0]));
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, '0, 0);
  endtask

  logic [PW-1:0] prev_pc;

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = 9'($urandom);
    rom[0] = 9'o123; rom[1] = 9'o456; rom[2] = 9'o701; rom[3] = 9'o070;
    bus.Start = 0; bus.Branch = 0; bus.BranchCond = 0; bus.Zero = 0;
    bus.BranchTarget = '0; bus.Halt = 0;
    m_mode = 0; m_pc = '0; m_ir = '0; m_vld = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, '0, 0);
    chk("rst_addr",   32'(bus.IMemAddr), 32'd0);
    chk("rst_valid",  32'(bus.IRValid),  32'd0);
    chk("rst_done",   32'(bus.Done),     32'd0);
    chk("rst_opcode", 32'(bus.Opcode),   32'd0);
    idle_step();
    idle_step();
    chk("idle_hold", 32'(bus.IMemAddr), 32'd0);

    // Sequential fetch from address 0
    step(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) idle_step();
    chk("seq_addr",   32'(bus.IMemAddr), 32'd4);
    chk("seq_opcode", 32'(bus.Opcode),   32'(3'o0));
    // Start while running is ignored
    step(0, 1, 0, 0, 0, '0, 0);
    chk("start_in_run", 32'(bus.IMemAddr), 32'd5);

    // Unconditional branch to 0x040: one bubble, then ROM[0x040]
    step(0, 0, 1, 0, 0, 10'h040, 0);
    chk("br_addr",   32'(bus.IMemAddr), 32'h040);
    chk("br_bubble", 32'(bus.IRValid),  32'd0);
    idle_step();
    chk("br_ir", 32'(bus.Opcode), 32'(rom[10'h040][8:6]));

    // Conditional branch, not taken then taken
    prev_pc = bus.IMemAddr;
    step(0, 0, 1, 1, 0, 10'h100, 0);
    chk("bez_nt_addr",  32'(bus.IMemAddr), 32'(prev_pc + 1'b1));
    chk("bez_nt_valid", 32'(bus.IRValid),  32'd1);
    step(0, 0, 1, 1, 1, 10'h100, 0);
    chk("bez_t_addr", 32'(bus.IMemAddr), 32'h100);
    idle_step();

    // Tight loop: branch to its own address
    prev_pc = bus.IMemAddr - 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, prev_pc, 0);
      idle_step();
    end

    // Halt with Branch also asserted: halt wins, PC frozen
    prev_pc = bus.IMemAddr;
    step(0, 0, 1, 0, 0, 10'h200, 1);
    chk("halt_done", 32'(bus.Done),     32'd1);
    chk("halt_pc",   32'(bus.IMemAddr), 32'(prev_pc));
    step(0, 0, 1, 0, 0, 10'h200, 1);
    chk("halted_pc", 32'(bus.IMemAddr), 32'(prev_pc));
    step(0, 1, 0, 0, 0, '0, 0);
    chk("restart_pc",   32'(bus.IMemAddr), 32'd0);
    chk("restart_done", 32'(bus.Done),     32'd0);
    idle_step();

    // PC wrap from 0x3FF to 0
    step(0, 0, 1, 0, 0, 10'h3FF, 0);
    idle_step();
    chk("wrap_pc", 32'(bus.IMemAddr), 32'd0);
    idle_step();

    // Reset overriding Start and Halt mid-run
    step(1, 1, 1, 0, 0, 10'h155, 1);
    chk("rst_run_pc",    32'(bus.IMemAddr), 32'd0);
    chk("rst_run_valid", 32'(bus.IRValid),  32'd0);
    chk("rst_run_done",  32'(bus.Done),     32'd0);

    // Random control traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom),
           1'($urandom),
           PW'($urandom),
           ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, instruction address width.
REQ-002 SHALL have parameter START_ADDR, default 0, PC load value on Start.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Start  input  1  begin program execution from START_ADDR.
REQ-006 SHALL have port InstrIn  input  9  instruction word from instruction ROM, combinational on IMemAddr.
REQ-007 SHALL have port Branch  input  1  from Control: instruction in IR is a branch.
REQ-008 SHALL have port BranchCond  input  1  from Control: 1 = taken only if Zero, 0 = unconditional.
REQ-009 SHALL have port Zero  input  1  condition operand is zero (from datapath).
REQ-010 SHALL have port BranchTarget  input  PC_WIDTH  absolute branch destination.
REQ-011 SHALL have port Halt  input  1  from Control: instruction in IR is halt.
REQ-012 SHALL have port IMemAddr  output  PC_WIDTH  current PC, drives ROM address.
REQ-013 SHALL have port Opcode  output  3  IR[8:6], to Control.
REQ-014 SHALL have port Funct  output  3  IR[2:0], to Control.
REQ-015 SHALL have port Operand  output  3  IR[5:3], to datapath.
REQ-016 SHALL have port IRValid  output  1  IR holds a live (non-squashed) instruction.
REQ-017 SHALL have port Done  output  1  program halted; high until next Start or Reset.

Function
REQ-018 SHALL implement state machine IDLE, RUN, HALTED; Reset enters IDLE.
REQ-019 SHALL, in IDLE or HALTED, hold PC and IR, keep IRValid=0, ignore Branch/Halt.
REQ-020 SHALL, on Start in IDLE or HALTED, load PC=START_ADDR, IRValid=0, Done=0, enter RUN next cycle.
REQ-021 SHALL ignore Start while in RUN.
REQ-022 SHALL, each RUN cycle with no taken redirect, load IR<=InstrIn, IRValid<=1, PC<=PC+1 (one-instruction fetch latency).
REQ-023 SHALL wrap PC from 2^PC_WIDTH-1 to 0 with no flag.
REQ-024 SHALL define taken = IRValid & Branch & (~BranchCond | Zero); Branch, Halt SHALL be ignored when IRValid=0.
REQ-025 SHALL, on taken, load PC<=BranchTarget and IRValid<=0 (squash the instruction fetched at the old PC; one bubble).
REQ-026 SHALL, on IRValid & Halt, enter HALTED, set Done=1, IRValid<=0, hold PC at its current value.
REQ-027 SHALL give Halt priority over Branch when both asserted.
REQ-028 SHALL allow a taken branch to target its own address (tight loop) with one bubble per iteration.
REQ-029 SHALL drive Opcode/Funct/Operand from IR regardless of IRValid.

Reset
REQ-030 SHALL, on Reset, set PC=START_ADDR, IR=0, IRValid=0, Done=0, state IDLE, overriding Start, Branch, Halt in the same cycle.
REQ-031 SHALL honour Reset mid-RUN or in HALTED identically, discarding any in-flight redirect.
REQ-032 SHALL hold IDLE after Reset until Start seen with Reset low.

Verification
REQ-033 Reset, Start, ROM = sequential non-branch words at 0..3 -> IMemAddr 0,1,2,3,4 on consecutive cycles; IRValid=1 from 2nd RUN cycle; Opcode/Funct track ROM[0..3].
REQ-034 IR holds br (Branch=1, BranchCond=0), BranchTarget=0x040 -> next IMemAddr=0x040, IRValid=0 one cycle, then IR=ROM[0x040].
REQ-035 IR holds bez, Zero=0 -> PC continues +1, no bubble; repeat with Zero=1 -> redirect to target with one bubble.
REQ-036 IR holds halt with Branch also forced 1 -> Done=1, state HALTED, PC frozen; Start -> PC=0, Done=0, fetch resumes.
REQ-037 PC=0x3FF in RUN -> next PC=0x000; Reset asserted with Start and Halt high -> PC=0, IRValid=0, Done=0, IDLE.
